// File: rtl/alu_unit_if.sv
// ---------------------------------------------------------------------------
// alu_unit_if
// Operand/result bundle for the registered 16-bit ALU.
//   in1     [15:0] operand A
//   in2     [15:0] operand B (low 4 bits are the shift amount for shifts)
//   alu_op  [2:0]  operation select
//   alu_out [15:0] registered result
//   z       [1:0]  registered flags: z[0] zero, z[1] negative
// master: the side issuing operations; slave: the ALU itself.
// ---------------------------------------------------------------------------
interface alu_unit_if;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic [1:0]  z;

  modport master (
    output in1,
    output in2,
    output alu_op,
    input  alu_out,
    input  z
  );

  modport slave (
    input  in1,
    input  in2,
    input  alu_op,
    output alu_out,
    output z
  );
endinterface

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
// 16-bit arithmetic/logic unit with a single output register stage.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high; clears result and flags at once
//   bus    : alu_unit_if.slave (in1, in2, alu_op in; alu_out, z out)
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical),
//          7 MUL (low 16 bits of unsigned product) when ALU_MUL_EN is
//          defined, otherwise 7 PASS (result = in1).
// Flags come from the truncated 16-bit result written on the same edge:
//   z[0] = result is zero, z[1] = result bit 15.
// Build option: define ALU_MUL_EN to replace PASS with MUL.
// ---------------------------------------------------------------------------
module alu_unit (
  input  logic   clock,
  input  logic   reset,
  alu_unit_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_EXT = 3'd7
  } alu_op_t;

  // Flag word for a result: {negative, zero}.
  function automatic logic [1:0] calc_flags(input logic [DATA_W-1:0] res);
    calc_flags = {res[DATA_W-1], (res == '0)};
  endfunction

  logic [DATA_W-1:0]  a_p0;
  logic [DATA_W-1:0]  b_p0;
  logic [SHAMT_W-1:0] shamt_p0;
  alu_op_t            op_p0;
  logic [DATA_W-1:0]  result_p0;
  logic [1:0]         flags_p0;

  logic [DATA_W-1:0]  alu_out_p1;
  logic [1:0]         z_p1;

  // ---- stage p0: combinational operation select ----
  assign a_p0     = bus.in1;
  assign b_p0     = bus.in2;
  assign shamt_p0 = bus.in2[SHAMT_W-1:0];
  assign op_p0    = alu_op_t'(bus.alu_op);

  always_comb begin
    result_p0 = '0;
    unique case (op_p0)
      OP_ADD: result_p0 = a_p0 + b_p0;
      OP_SUB: result_p0 = a_p0 - b_p0;
      OP_AND: result_p0 = a_p0 & b_p0;
      OP_OR:  result_p0 = a_p0 | b_p0;
      OP_XOR: result_p0 = a_p0 ^ b_p0;
      OP_SHL: result_p0 = a_p0 << shamt_p0;
      OP_SHR: result_p0 = a_p0 >> shamt_p0;
`ifdef ALU_MUL_EN
      // Only the low half of the product is kept.
      OP_EXT: result_p0 = a_p0 * b_p0;
`else
      OP_EXT: result_p0 = a_p0;
`endif
      default: result_p0 = '0;
    endcase
  end

  assign flags_p0 = calc_flags(result_p0);

  // ---- stage p1: output register ----
  // Reset clears the result too: a zero result with z[0]=0 is the
  // distinguishable "nothing computed" state seen by the sequencer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_out_p1 <= '0;
      z_p1       <= 2'b00;
    end else begin
      alu_out_p1 <= result_p0;
      z_p1       <= flags_p0;
    end
  end

  assign bus.alu_out = alu_out_p1;
  assign bus.z       = z_p1;

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  logic clock = 1'b0;
  logic reset;

  alu_unit_if bus ();

  alu_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference behaviour from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [2:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    longint ai, bi, r;
    int sh;
    logic [15:0] r16;
    ai = longint'(a);
    bi = longint'(b);
    sh = int'(b) % 16;
    r  = 0;
    case (op)
      3'd0: r = (ai + bi) % 65536;
      3'd1: r = (ai - bi + 65536) % 65536;
      3'd2: r = longint'(a & b);
      3'd3: r = longint'(a | b);
      3'd4: r = longint'(a ^ b);
      3'd5: r = (ai * (longint'(1) << sh)) % 65536;
      3'd6: r = ai / (longint'(1) << sh);
`ifdef ALU_MUL_EN
      3'd7: r = (ai * bi) % 65536;
`else
      3'd7: r = ai;
`endif
      default: r = 0;
    endcase
    r16 = r[15:0];
    model = {(r >= 32768), (r == 0), r16};
  endfunction

  task automatic check(input string name, input logic [15:0] got_out, input logic [1:0] got_z,
                       input logic [15:0] exp_out, input logic [1:0] exp_z);
    tests++;
    if (got_out !== exp_out || got_z !== exp_z) begin
      fails++;
      $display("FAIL %s: got alu_out=%h z=%b, expected alu_out=%h z=%b",
               name, got_out, got_z, exp_out, exp_z);
    end
  endtask

  // Model tracks what the registered outputs must be.
  logic [15:0] exp_out = 16'h0;
  logic [1:0]  exp_z = 2'b00;
  logic        model_valid = 1'b0;

  always @(posedge clock or posedge reset) begin
    logic [17:0] m;
    if (reset) begin
      exp_out     = 16'h0;
      exp_z       = 2'b00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m       = model(bus.alu_op, bus.in1, bus.in2);
      exp_out = m[15:0];
      exp_z   = m[17:16];
    end
  end

  // Cycle compare, mid-cycle away from the edge.
  always begin
    @(posedge clock);
    #5;
    if (model_valid) check("model", bus.alu_out, bus.z, exp_out, exp_z);
  end

  // Issue one op at posedge+2, check the literal result at the next posedge+1.
  task automatic op_check(input string name, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eo, input logic [1:0] ez);
    bus.alu_op = op;
    bus.in1    = a;
    bus.in2    = b;
    @(posedge clock);
    #1;
    check(name, bus.alu_out, bus.z, eo, ez);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    bus.in1    = 16'h0;
    bus.in2    = 16'h0;
    bus.alu_op = 3'd0;
    @(posedge clock);
    #2;
    check("reset_init", bus.alu_out, bus.z, 16'h0000, 2'b00);
    reset = 1'b0;

    // Add sequence, back to back
    op_check("add_1_2",      3'd0, 16'd1,     16'd2,   16'd3,     2'b00);
    op_check("add_20_100",   3'd0, 16'd20,    16'd100, 16'd120,   2'b00);
    op_check("add_wrap",     3'd0, 16'hFFFF,  16'd1,   16'h0000,  2'b01);
    // Subtract
    op_check("sub_10_3",     3'd1, 16'd10,    16'd3,   16'd7,     2'b00);
    op_check("sub_2_8",      3'd1, 16'd2,     16'd8,   16'hFFFA,  2'b10);
    op_check("sub_5_5",      3'd1, 16'd5,     16'd5,   16'h0000,  2'b01);
    // Logic and shifts
    op_check("and_5_6",      3'd2, 16'd5,     16'd6,   16'd4,     2'b00);
    op_check("or_10_1",      3'd3, 16'd10,    16'd1,   16'd11,    2'b00);
    op_check("xor",          3'd4, 16'hFFFF,  16'h8000, 16'h7FFF, 2'b00);
    op_check("shl_hi_ign",   3'd5, 16'd1,     16'h0013, 16'h0008, 2'b00);
    op_check("shl_15",       3'd5, 16'd1,     16'd15,  16'h8000,  2'b10);
    op_check("shr_15",       3'd6, 16'h8000,  16'd15,  16'd1,     2'b00);
    op_check("shr_out",      3'd6, 16'h0001,  16'd1,   16'h0000,  2'b01);
    // Opcode 7
`ifdef ALU_MUL_EN
    op_check("mul_300",      3'd7, 16'd300,   16'd300, 16'h5F90,  2'b00);
`else
    op_check("pass_8001",    3'd7, 16'h8001,  16'd0,   16'h8001,  2'b10);
`endif

    // Async reset mid-cycle after loading 0xFFFA
    op_check("sub_pre_rst",  3'd1, 16'd2,     16'd8,   16'hFFFA,  2'b10);
    bus.alu_op = 3'd0;
    bus.in1    = 16'd1;
    bus.in2    = 16'd2;
    #10;
    reset = 1'b1;
    #1;
    check("rst_async", bus.alu_out, bus.z, 16'h0000, 2'b00);
    @(posedge clock);
    #1;
    check("rst_hold", bus.alu_out, bus.z, 16'h0000, 2'b00);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_add", bus.alu_out, bus.z, 16'd3, 2'b00);
    #1;

    // Latency: inputs changed between edges do not move the outputs
    op_check("lat_base",     3'd0, 16'd20,    16'd100, 16'd120,   2'b00);
    bus.alu_op = 3'd2;
    bus.in1    = 16'd5;
    bus.in2    = 16'd6;
    #6;
    bus.alu_op = 3'd3;
    bus.in1    = 16'd10;
    bus.in2    = 16'd1;
    #1;
    check("lat_hold", bus.alu_out, bus.z, 16'd120, 2'b00);
    @(posedge clock);
    #1;
    check("lat_new", bus.alu_out, bus.z, 16'd11, 2'b00);

    @(posedge clock);
    #7;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
